backscatter_fsk_mod: RTL
========================

// Module: backscatter_fsk_mod
// PURPOSE
//  Parametrised single-clock backscatter modulator. Replaces fixed PLL-derived switch clocks with on-chip
//  dividers. Frames are FSK: symbol 0 uses subcarrier half-period div0 and symbol 1 uses div1.
//  The subcarrier rotates a one-hot pattern over NUM_CH antenna-load switches (ctrl).
//  Sits between the board clock domain (12 MHz) and the RF switch pins. A frame is triggered by the
//  start pulse or by a debounced push-button.
// PARAMETERS
//  NUM_CH      4       number of one-hot switch control outputs (>=2)
//  DIV_W       16      width of div0/div1 and half-period counter
//  FRAME_BITS  32      payload bits per frame, sent MSB first
//  BIT_CYC     1200    clk cycles per symbol (>=2)
//  PRE_LEN     8       preamble bits (only with BSC_PREAMBLE_EN)
//  PREAMBLE    8'hA5   preamble pattern, MSB first (PRE_LEN bits)
//  DB_CYC      240000  debounce stability window in clk cycles (20 ms @ 12 MHz)
// PORTS
//  clk      in   1           system clock; all logic on rising edge
//  rst      in   1           synchronous reset, active-high
//  div0     in   DIV_W       half-period (cycles) of subcarrier for symbol 0; 0 treated as 1
//  div1     in   DIV_W       half-period (cycles) of subcarrier for symbol 1; 0 treated as 1
//  payload  in   FRAME_BITS  frame data, latched on the trigger cycle
//  start    in   1           frame trigger, sampled each cycle
//  key0     in   1           raw push-button, active-low, asynchronous
//  busy     out  1           frame in progress
//  done     out  1           1-cycle pulse at frame end
//  ctrl     out  NUM_CH      one-hot switch drive; all 0 when idle
//  clkp     out  1           subcarrier reference square wave; 0 when idle
//  led0     out  1           toggles on every completed frame
// BEHAVIOUR
//  Reset: busy=0, done=0, ctrl=0, clkp=0, led0=0. FSM=IDLE. Counters=0. Debounced key=1 (released).
//  Reset mid-frame aborts immediately: no done pulse, no led0 toggle.
//  Key path: 2-FF synchroniser. Stable value changes only after the synchronised input has differed
//  from it for DB_CYC consecutive cycles. A press event is a stable 1->0 transition.
//  Trigger = start | press event. It is taken only in IDLE. Triggers while busy or in DONE are dropped,
//  not queued.
//  FSM: IDLE -> (PRE) -> DATA -> DONE -> IDLE.
//   - IDLE -> PRE/DATA: on the trigger cycle t. The payload is latched and the first symbol is loaded.
//   - At t+1: busy=1, ctrl=1 (ctrl[0] active), clkp=1.
//   - Each symbol lasts exactly BIT_CYC cycles, timed by a symbol counter.
//   - The last symbol ends at cycle t+N*BIT_CYC (N = symbols/frame).
//   - At t+1+N*BIT_CYC: FSM is in DONE, done=1, busy=0, ctrl=0, clkp=0, led0 toggles.
//   - The following cycle returns to IDLE.
//  Subcarrier:
//   - div_cur = (sym ? div1 : div0), substituting 1 if 0. Sampled only at each symbol start;
//     mid-symbol changes on div0/div1 are ignored.
//   - Half-period counter hc: when hc >= div_cur-1, clkp toggles, hc=0 and the ctrl one-hot rotates
//     left by 1. Rotation wraps ctrl[NUM_CH-1] -> ctrl[0]. Otherwise hc++.
//   - Phase is continuous across symbol boundaries: hc and the ctrl position are not reset.
//     If the new div_cur <= hc, the toggle occurs on the next cycle.
//   - hc, clkp and the ctrl position restart from 0/1/ctrl[0] at each frame start.
//  Exactly one ctrl bit is high whenever busy=1.
//  Symbol/bit counters are sized by $clog2; no overflow is possible within legal parameters.
// CONFIGURATION
//  BSC_PREAMBLE_EN defined:
//   - PRE_LEN bits of PREAMBLE precede the payload.
//   - N = PRE_LEN + FRAME_BITS.
//   - FSM visits PRE.
//  BSC_PREAMBLE_EN undefined:
//   - No PRE state; the first payload bit starts at t+1.
//   - N = FRAME_BITS.
//   - PRE_LEN and PREAMBLE are unused.
// TESTING (NUM_CH=4, BIT_CYC=16, FRAME_BITS=4, DB_CYC=8, div0=2, div1=4, no preamble)
//  1. Reset 5 cycles -> busy=done=ctrl=clkp=led0=0. Then idle 50 cycles -> all outputs stay 0.
//  2. start=1 for 1 cycle at t, payload=4'b1010:
//     -> busy=1 over t+1..t+64; done=1 at t+65 only; led0=1.
//     -> clkp half-period 4 cycles for symbols 1 and 3, 2 cycles for symbols 2 and 4.
//     -> ctrl steps 0001,0010,0100,1000,0001 at each clkp edge.
//  3. start pulses at t+10 and t+65 during the frame of test 2 -> ignored; only one done; busy length unchanged.
//  4. key0 glitch low for 5 cycles -> no frame.
//     key0 held low for 20 cycles -> exactly one frame, starting 2+8 (+1 edge) cycles after the fall.
//     Release, then press again -> second frame.
//  5. div0=0 -> treated as 1: clkp toggles every cycle during 0-symbols.
//     Change div1 mid-symbol -> no effect until the next symbol start.
//  6. Assert rst at t+30 of a frame -> next cycle all outputs 0, no done, led0 unchanged.
//     Then start -> a normal frame.
//     Repeat tests 2 and 6 with BSC_PREAMBLE_EN defined (PRE_LEN=8) -> busy spans 192 cycles, first 8 symbols = A5.

Source files
------------

// File: rtl/backscatter_fsk_mod.sv
// backscatter_fsk_mod
// Single-clock FSK backscatter modulator. Each symbol picks a subcarrier
// half-period (div0 for '0', div1 for '1'). The subcarrier steps a one-hot
// pattern across NUM_CH antenna-load switches and drives the clkp reference.
// A frame starts on the start pulse or on a debounced press of key0.
//
// Build option: define BSC_PREAMBLE_EN to send PRE_LEN bits of PREAMBLE
// (MSB first) ahead of the payload. Without it, the first payload bit goes
// out on the cycle after the trigger.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | outputs quiet, waiting for start or a key press
// S_PRE  | sending preamble symbols (BSC_PREAMBLE_EN builds only)
// S_DATA | sending payload symbols, MSB first
// S_DONE | one-cycle frame-end pulse; triggers here are dropped

module backscatter_fsk_mod #(
   parameter int unsigned        NUM_CH     = 4,
   parameter int unsigned        DIV_W      = 16,
   parameter int unsigned        FRAME_BITS = 32,
   parameter int unsigned        BIT_CYC    = 1200,
   parameter int unsigned        PRE_LEN    = 8,
   parameter logic [PRE_LEN-1:0] PREAMBLE   = 8'hA5,
   parameter int unsigned        DB_CYC     = 240000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIV_W-1:0]      div0,
   input  logic [DIV_W-1:0]      div1,
   input  logic [FRAME_BITS-1:0] payload,
   input  logic                  start,
   input  logic                  key0,
   output logic                  busy,
   output logic                  done,
   output logic [NUM_CH-1:0]     ctrl,
   output logic                  clkp,
   output logic                  led0
);

`ifdef BSC_PREAMBLE_EN
   localparam int unsigned N_SYM = PRE_LEN + FRAME_BITS;
`else
   localparam int unsigned N_SYM = FRAME_BITS;
`endif

   localparam int unsigned SC_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam int unsigned BL_W = (N_SYM > 1)   ? $clog2(N_SYM)   : 1;
   localparam int unsigned DB_W = (DB_CYC > 1)  ? $clog2(DB_CYC)  : 1;

   localparam logic [SC_W-1:0]   SC_LOAD = SC_W'(BIT_CYC - 1);
   localparam logic [BL_W-1:0]   BL_LOAD = BL_W'(N_SYM - 1);
   localparam logic [DB_W-1:0]   DB_TC   = DB_W'(DB_CYC - 1);
   localparam logic [NUM_CH-1:0] CH0     = NUM_CH'(1);
`ifdef BSC_PREAMBLE_EN
   // symbols still to go after the last preamble symbol equals FRAME_BITS
   localparam logic [BL_W-1:0]   BL_PRE_END = BL_W'(FRAME_BITS);
`endif

   if (NUM_CH < 2 || BIT_CYC < 2 || DB_CYC < 1 || PRE_LEN < 1 ||
       $bits(PREAMBLE) != PRE_LEN) begin : g_bad_params
      $error("backscatter_fsk_mod: illegal parameter set");
   end

`ifdef BSC_PREAMBLE_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } state_t;
`endif

   state_t state, state_nx;

   // key debounce path
   logic             key_s1, key_s2;
   logic             key_st, key_st_d;
   logic [DB_W-1:0]  db_cnt;
   logic             press;
   logic             trig;

   // frame datapath
   logic [N_SYM-1:0]  sr;
   logic [N_SYM-1:0]  sr_shift;
   logic [N_SYM-1:0]  load_vec;
   logic [BL_W-1:0]   bits_left;
   logic [SC_W-1:0]   sym_cnt;
   logic [DIV_W-1:0]  div_cur;
   logic [DIV_W-1:0]  hc;
   logic              clkp_r;
   logic [NUM_CH-1:0] ctrl_r;
   logic              led0_r;

   logic              busy_st;
   logic              frame_go;
   logic              sym_end;
   logic              half_tc;

   // half-period for a symbol value; a programmed 0 would stall the subcarrier, so it runs as 1
   function automatic logic [DIV_W-1:0] half_of(input logic b,
                                                input logic [DIV_W-1:0] d0,
                                                input logic [DIV_W-1:0] d1);
      logic [DIV_W-1:0] d;
      d = b ? d1 : d0;
      if (d == '0) d = DIV_W'(1);
      return d;
   endfunction

`ifdef BSC_PREAMBLE_EN
   assign load_vec = {PREAMBLE, payload};
   assign busy_st  = (state == S_PRE) || (state == S_DATA);
`else
   assign load_vec = payload;
   assign busy_st  = (state == S_DATA);
`endif

   assign sr_shift = sr << 1;
   assign press    = key_st_d & ~key_st;
   assign trig     = start | press;
   assign frame_go = (state == S_IDLE) && trig;
   assign sym_end  = (sym_cnt == '0);
   assign half_tc  = (hc >= (div_cur - DIV_W'(1)));

   assign busy = busy_st;
   assign done = (state == S_DONE);
   assign ctrl = busy_st ? ctrl_r : '0;
   assign clkp = busy_st & clkp_r;
   assign led0 = led0_r;

   // key0: 2-FF synchroniser, then the stable level moves only after DB_CYC differing cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         key_s1   <= 1'b1;
         key_s2   <= 1'b1;
         key_st   <= 1'b1;
         key_st_d <= 1'b1;
         db_cnt   <= '0;
      end else begin
         key_s1   <= key0;
         key_s2   <= key_s1;
         key_st_d <= key_st;
         if (key_s2 == key_st) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_TC) begin
            key_st <= key_s2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // next-state logic; triggers outside IDLE are simply not looked at
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (trig) begin
`ifdef BSC_PREAMBLE_EN
               state_nx = S_PRE;
`else
               state_nx = S_DATA;
`endif
            end
         end
`ifdef BSC_PREAMBLE_EN
         S_PRE: begin
            if (sym_end && (bits_left == BL_PRE_END)) state_nx = S_DATA;
         end
`endif
         S_DATA: begin
            if (sym_end && (bits_left == '0)) state_nx = S_DONE;
         end
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // symbol timing, subcarrier phase and switch rotation; phase carries across symbol edges
   always_ff @(posedge clk) begin
      if (rst) begin
         sr        <= '0;
         bits_left <= '0;
         sym_cnt   <= '0;
         div_cur   <= '0;
         hc        <= '0;
         clkp_r    <= 1'b0;
         ctrl_r    <= '0;
      end else if (frame_go) begin
         sr        <= load_vec;
         bits_left <= BL_LOAD;
         sym_cnt   <= SC_LOAD;
         div_cur   <= half_of(load_vec[N_SYM-1], div0, div1);
         hc        <= '0;
         clkp_r    <= 1'b1;
         ctrl_r    <= CH0;
      end else if (busy_st) begin
         if (half_tc) begin
            hc     <= '0;
            clkp_r <= ~clkp_r;
            ctrl_r <= {ctrl_r[NUM_CH-2:0], ctrl_r[NUM_CH-1]};
         end else begin
            hc <= hc + DIV_W'(1);
         end
         if (sym_end) begin
            sym_cnt <= SC_LOAD;
            sr      <= sr_shift;
            div_cur <= half_of(sr_shift[N_SYM-1], div0, div1);
            if (bits_left != '0) bits_left <= bits_left - BL_W'(1);
         end else begin
            sym_cnt <= sym_cnt - SC_W'(1);
         end
      end
   end

   // frame-complete indicator flips as the FSM enters DONE; aborted frames never get here
   always_ff @(posedge clk) begin
      if (rst)                                      led0_r <= 1'b0;
      else if (state == S_DATA && state_nx == S_DONE) led0_r <= ~led0_r;
   end

endmodule
